pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage RV32 pipeline. Drives stall/flush of the F/D, D/E, E/M, M/W
//  pipeline registers (FlushE -> CLR of the D->E register) and operand-forward selects for the E stage.
//  Sequences variable-latency data-memory accesses with an IDLE/MEM_WAIT FSM, timeout watchdog and
//  saturating stall/flush performance counters.
// PARAMETERS
//  TIMEOUT  256  MEM_WAIT cycles before MemErr is set
//  CNT_W    32   width of perf counters
// PORTS
//  CLK            in   1      clock, rising edge
//  RST            in   1      reset, asynchronous, active-high
//  Rs1D, Rs2D     in   5      source regs in D
//  Rs1E, Rs2E     in   5      source regs in E
//  RdE, RdM, RdW  in   5      dest regs in E/M/W
//  ResultSrcE     in   3      result select in E; RES_MEM (3'b001) marks a load
//  RegWriteM/W    in   1      write-enable in M/W
//  PCSrcE         in   1      taken branch/jump resolved in E
//  MemReqM        in   1      M-stage instruction accesses data memory
//  MemReadyM      in   1      data memory completes access this cycle
//  StallF, StallD, StallE, StallM  out 1  hold respective pipeline register
//  FlushD, FlushE, FlushW          out 1  clear (bubble) respective register
//  ForwardAE, ForwardBE            out 2  00 regfile, 01 W result, 10 M ALU result
//  MemErr         out  1      sticky memory-timeout flag
//  StallCnt       out  CNT_W  cycles with StallF=1, saturating
//  FlushCnt       out  CNT_W  cycles with branch flush, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, MemErr 0; combinational outputs forced 0 while RST=1.
//  - Forward (A shown, B same with Rs2E): 10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if RegWriteW &&
//    RdW!=0 && RdW==Rs1E; else 00. M beats W. x0 never forwarded. Zero latency.
//  - memStall = (IDLE ? MemReqM && !MemReadyM : !MemReadyM). Same-cycle (no latency).
//  - lwStall = ResultSrcE==RES_MEM && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//  - Priority 1, memStall: StallF=StallD=StallE=StallM=1, FlushW=1; FlushD=FlushE=0 (PCSrcE/lwStall deferred;
//    frozen E re-presents them after release).
//  - Priority 2, PCSrcE: FlushD=FlushE=1, StallF=StallD=0 (lwStall ignored; D is wrong-path).
//  - Priority 3, lwStall: StallF=StallD=1, FlushE=1 -> exactly one bubble; next cycle forwarding W->E covers it.
//  - FSM: IDLE->MEM_WAIT when MemReqM && !MemReadyM; MEM_WAIT->IDLE on MemReadyM (stall drops that cycle);
//    MemReqM ignored in MEM_WAIT. Ready in the request cycle: no stall, stay IDLE.
//  - Watchdog: counter clears in IDLE, +1 per MEM_WAIT cycle; reaching TIMEOUT sets MemErr (sticky until RST).
//    FSM keeps waiting; counter holds at TIMEOUT.
//  - Counters: StallCnt +1 on cycles with StallF=1; FlushCnt +1 on cycles with priority-2 flush.
//    Both saturate at all-ones, no wrap.
//  - RST mid-MEM_WAIT: immediately IDLE, all stalls deassert, counters/MemErr cleared.
// STRUCTURE
//  - hazard_pkg: RES_MEM constant, fwd_sel_e {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10},
//    mem_state_e {IDLE, MEM_WAIT}.
//  - Sub-module sat_counter #(W) (CLK, RST, inc, q), instanced for StallCnt and FlushCnt.
//  - Rest: comb forward/priority logic + FSM/watchdog always_ff in this module.
// TESTING
//  1 RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; RdM=0,Rs1E=0 -> ForwardAE=00.
//  2 ResultSrcE=001,RdE=7,Rs2D=7 -> StallF=StallD=FlushE=1 one cycle, StallCnt=1; next cycle no stall.
//  3 PCSrcE=1 with lwStall -> FlushD=FlushE=1, StallF=0, FlushCnt+1.
//  4 MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> StallF..M=FlushW=1 for 3 cycles, IDLE after, StallCnt=3.
//  5 TIMEOUT=4, MemReadyM held 0 -> MemErr=1 after 4th MEM_WAIT cycle, stays 1; RST -> all outputs 0.
//  6 CNT_W=4, stall 20 cycles -> StallCnt=15, holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 pipeline hazard controller.
// The forwarding rule lives here so that operand A and operand B use one definition.
package hazard_pkg;

    localparam logic [2:0] RES_MEM = 3'b001;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    // The M stage is younger than W, so it wins; x0 is hard-wired and never forwarded.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic       reg_write_m,
        input logic [4:0] rd_m,
        input logic       reg_write_w,
        input logic [4:0] rd_w
    );
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_M;
        else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Once all ones it holds its value until reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] q
);

    // NOTE: sequential state is always written with non-blocking assignments.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: stall/flush control,
// E-stage operand forwarding, data-memory wait FSM with timeout watchdog and perf counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [2:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int              WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_TIMEOUT = WD_W'(TIMEOUT);

    mem_state_e      r_state;
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_mem_err;

    logic w_mem_stall;
    logic w_lw_stall;
    logic w_branch_flush;

    assign w_mem_stall = (r_state == IDLE) ? (MemReqM && !MemReadyM) : !MemReadyM;
    assign w_lw_stall  = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
                         ((RdE == Rs1D) || (RdE == Rs2D));

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        StallF         = 1'b0;
        StallD         = 1'b0;
        StallE         = 1'b0;
        StallM         = 1'b0;
        FlushD         = 1'b0;
        FlushE         = 1'b0;
        FlushW         = 1'b0;
        ForwardAE      = FWD_RF;
        ForwardBE      = FWD_RF;
        w_branch_flush = 1'b0;
        if (!RST) begin
            ForwardAE = fwd_select(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
            ForwardBE = fwd_select(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
            // Frozen E keeps PCSrcE/lwStall alive, so they are simply re-evaluated after the memory stall.
            if (w_mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                FlushD         = 1'b1;
                FlushE         = 1'b1;
                w_branch_flush = 1'b1;
            end else if (w_lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Watchdog counts MEM_WAIT cycles and parks at TIMEOUT; the FSM itself keeps waiting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= IDLE;
            r_wd_cnt  <= '0;
            r_mem_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wd_cnt <= '0;
                    if (MemReqM && !MemReadyM)
                        r_state <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    if (r_wd_cnt != WD_TIMEOUT)
                        r_wd_cnt <= r_wd_cnt + WD_W'(1);
                    if ((r_wd_cnt + WD_W'(1)) == WD_TIMEOUT)
                        r_mem_err <= 1'b1;
                    if (MemReadyM)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign MemErr = r_mem_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (StallF),
        .q   (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (w_branch_flush),
        .q   (FlushCnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level reference model (TIMEOUT=4, CNT_W=4 to reach edge cases fast).
module tb_pipeline_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [2:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: "are we waiting on memory", how long, and event tallies.
    bit m_waiting;
    int m_wait_cycles;
    bit m_err;
    int m_stall_cnt;
    int m_flush_cnt;
    bit m_last_stallf;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    // Compare every output against the model at the negative edge (inputs already settled).
    task automatic settle_and_check(input string tag);
        bit         mem_stall, lw;
        logic [6:0] exp_ctl, got_ctl;
        @(negedge CLK);
        mem_stall = m_waiting ? !MemReadyM : (MemReqM && !MemReadyM);
        lw = (ResultSrcE == 3'b001) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
        if (mem_stall)   exp_ctl = 7'b1111_001;
        else if (PCSrcE) exp_ctl = 7'b0000_110;
        else if (lw)     exp_ctl = 7'b1100_010;
        else             exp_ctl = 7'b0000_000;
        got_ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
        n_checks++;
        if (got_ctl !== exp_ctl) begin
            n_errors++;
            $display("FAIL %s ctl: got %b expected %b", tag, got_ctl, exp_ctl);
        end
        n_checks++;
        if ({ForwardAE, ForwardBE} !== {ref_fwd(Rs1E), ref_fwd(Rs2E)}) begin
            n_errors++;
            $display("FAIL %s fwd: got %b/%b expected %b/%b", tag, ForwardAE, ForwardBE,
                     ref_fwd(Rs1E), ref_fwd(Rs2E));
        end
        n_checks++;
        if (MemErr !== m_err) begin
            n_errors++;
            $display("FAIL %s memerr: got %b expected %b", tag, MemErr, m_err);
        end
        n_checks++;
        if (StallCnt !== CNT_W'(m_stall_cnt)) begin
            n_errors++;
            $display("FAIL %s stallcnt: got %0d expected %0d", tag, StallCnt, m_stall_cnt);
        end
        n_checks++;
        if (FlushCnt !== CNT_W'(m_flush_cnt)) begin
            n_errors++;
            $display("FAIL %s flushcnt: got %0d expected %0d", tag, FlushCnt, m_flush_cnt);
        end
        // Advance the model to what the next rising edge will produce.
        m_last_stallf = exp_ctl[6];
        if (exp_ctl[6] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (!mem_stall && PCSrcE && m_flush_cnt < CNT_MAX) m_flush_cnt++;
        if (m_waiting) begin
            m_wait_cycles++;
            if (m_wait_cycles >= TIMEOUT) m_err = 1;
            if (MemReadyM) m_waiting = 0;
        end else begin
            m_wait_cycles = 0;
            if (MemReqM && !MemReadyM) m_waiting = 1;
        end
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
    endtask

    task automatic step(input string tag);
        settle_and_check(tag);
        advance();
    endtask

    task automatic model_reset();
        m_waiting = 0; m_wait_cycles = 0; m_err = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    endtask

    // Assert reset with inputs that would otherwise stall, flush and forward.
    task automatic test_reset();
        RST = 1'b1;
        Rs1E = 5'd3; Rs2E = 5'd3; RdM = 5'd3; RegWriteM = 1; PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
        ResultSrcE = 3'b001; RdE = 5'd9; Rs1D = 5'd9;
        #1;
        n_checks++;
        if ({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE,
             MemErr, StallCnt, FlushCnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got ctl=%b fa=%b fb=%b err=%b sc=%0d fc=%0d expected all 0",
                     {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
                     ForwardAE, ForwardBE, MemErr, StallCnt, FlushCnt);
        end
        model_reset();
        @(negedge CLK);
        idle_inputs();
        #1 RST = 1'b0;
        advance();
    endtask

    task automatic test_forward();
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5;
        settle_and_check("fwd_m_beats_w");
        n_checks++;
        if (ForwardAE !== 2'b10) begin
            n_errors++;
            $display("FAIL fwd_m_priority: got %b expected 10", ForwardAE);
        end
        advance();
        RdM = 0; Rs1E = 0; RdW = 0; Rs2E = 6; RdW = 6;
        settle_and_check("fwd_x0");
        n_checks++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b01) begin
            n_errors++;
            $display("FAIL fwd_x0_and_w: got %b/%b expected 00/01", ForwardAE, ForwardBE);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_load_use();
        ResultSrcE = 3'b001; RdE = 7; Rs2D = 7;
        settle_and_check("lw_stall");
        n_checks++;
        if ({StallF, StallD, FlushE} !== 3'b111) begin
            n_errors++;
            $display("FAIL lw_stall: got %b expected 111", {StallF, StallD, FlushE});
        end
        advance();
        ResultSrcE = 3'b000; RdE = 0;
        settle_and_check("lw_release");
        n_checks++;
        if (StallF !== 1'b0 || StallCnt !== CNT_W'(1)) begin
            n_errors++;
            $display("FAIL lw_release: got stallf=%b cnt=%0d expected 0 and 1", StallF, StallCnt);
        end
        advance();
        idle_inputs();
    endtask

    task automatic test_branch_over_lw();
        ResultSrcE = 3'b001; RdE = 8; Rs1D = 8; PCSrcE = 1;
        settle_and_check("branch_lw");
        n_checks++;
        if ({FlushD, FlushE, StallF, StallD} !== 4'b1100) begin
            n_errors++;
            $display("FAIL branch_priority: got %b expected 1100", {FlushD, FlushE, StallF, StallD});
        end
        advance();
        idle_inputs();
        settle_and_check("branch_after");
        n_checks++;
        if (FlushCnt !== CNT_W'(1)) begin
            n_errors++;
            $display("FAIL branch_flushcnt: got %0d expected 1", FlushCnt);
        end
        advance();
    endtask

    // Three not-ready cycles, then ready: three stall cycles and back to normal.
    task automatic test_mem_wait();
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            settle_and_check("mem_wait");
            n_checks++;
            if ({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE} !== 7'b1111100) begin
                n_errors++;
                $display("FAIL mem_stall_c%0d: got %b expected 1111100", i,
                         {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE});
            end
            advance();
            MemReqM = 0;
        end
        MemReadyM = 1; PCSrcE = 0;
        settle_and_check("mem_ready");
        n_checks++;
        if (StallF !== 1'b0 || StallCnt !== CNT_W'(3)) begin
            n_errors++;
            $display("FAIL mem_release: got stallf=%b cnt=%0d expected 0 and 3", StallF, StallCnt);
        end
        advance();
        idle_inputs();
        MemReqM = 1; MemReadyM = 1;
        settle_and_check("mem_ready_same_cycle");
        advance();
        idle_inputs();
        step("mem_idle_after");
    endtask

    // Hold not-ready: MemErr rises after the TIMEOUT-th waiting cycle and sticks; counter saturates.
    task automatic test_timeout_and_saturation();
        MemReqM = 1; MemReadyM = 0;
        step("to_enter");
        MemReqM = 0;
        for (int i = 1; i <= 20; i++) begin
            settle_and_check("to_wait");
            n_checks++;
            if (MemErr !== (i > TIMEOUT)) begin
                n_errors++;
                $display("FAIL timeout_w%0d: got %b expected %b", i, MemErr, (i > TIMEOUT));
            end
            advance();
        end
        settle_and_check("sat_hold");
        n_checks++;
        if (StallCnt !== CNT_W'(15) || MemErr !== 1'b1) begin
            n_errors++;
            $display("FAIL stallcnt_sat: got cnt=%0d err=%b expected 15 and 1", StallCnt, MemErr);
        end
        advance();
        test_reset();
        step("after_reset_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                test_reset();
            end
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
            RdW = 5'($urandom_range(0, 3));
            ResultSrcE = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'($urandom_range(0, 7));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            PCSrcE = ($urandom_range(0, 7) == 0);
            MemReqM = ($urandom_range(0, 3) == 0);
            MemReadyM = ($urandom_range(0, 2) != 0);
            step("random");
        end
    endtask

    initial begin
        idle_inputs();
        RST = 1'b0;
        model_reset();
        #2;
        test_reset();
        test_forward();
        test_reset();
        test_load_use();
        test_reset();
        test_branch_over_lw();
        test_reset();
        test_mem_wait();
        test_reset();
        test_timeout_and_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
